rectangle_inv_key_schedule: RTL
===============================

# rectangle_inv_key_schedule

Decryption-side key scheduler for the RECTANGLE-80 datapath. It generates the 26 round keys in reverse order, K25 down to K0, so the decryption core can use them as it consumes rounds. After a start pulse, the block runs the forward schedule for 25 cycles to reach K25. It then walks backward one inverse round per accepted valid/ready handshake. No key storage RAM is needed.

## Interface
- No parameters; round count is fixed at 25 and key width at 80.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- master_key  in  80  K0; sampled on the cycle start is accepted
- busy  out  1  high in FWD and EMIT
- rk_valid  out  1  rk_data/rk_idx hold a round key
- rk_ready  in  1  consumer accepts the key when rk_valid && rk_ready
- rk_data  out  64  round key = {Row3,Row2,Row1,Row0} of the current state
- rk_idx  out  5  index of the presented key, 25 down to 0
- rk_last  out  1  rk_valid && rk_idx==0
- ks_err  out  1  self-check failure flag (see Configuration)

## Operation
- State S is 80 bits, split into rows: Row_r = S[16r+15:16r], r=0..4.
- Forward round i (RC[i]):
  - S-box on columns j=0..3, nibble {Row3[j],Row2[j],Row1[j],Row0[j]}.
  - S-box table: 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2.
  - R0'=(R0<<<8)^R1, R1'=R2, R2'=R3, R3'=(R3<<<12)^R4, R4'=R0.
  - Then R0'[4:0] ^= RC[i].
- Inverse round using RC[i] (steps are applied in this order):
  - Undo the round constant: R0'[4:0] ^= RC[i].
  - Undo the Feistel step: R0=R4', R4=R3'^(R2'<<<12), R3=R2', R2=R1', R1=R0'^(R0<<<8).
  - Inverse S-box on the same columns, table 9,4,F,A,E,1,0,6,C,7,3,8,2,B,5,D.
- Round constants come from a 5-bit LFSR register rc.
  - Forward step: rc'={rc[3:0], rc[4]^rc[2]}.
  - Backward step: rc_prev={rc[0]^rc[3], rc[4:1]}.
  - RC[0]=5'h01, and the sequence runs 01,02,04,09,12,05,0B,16,0C,19,13,07,0F,1F,1E,1C,18,11,03,06,0D,1B,17,0E,1D.
- FSM states:
  - IDLE: start loads S<=master_key, rc<=01 and cnt<=0, then goes to FWD.
  - FWD: applies one forward round per cycle and advances rc. After cnt reaches 24 it goes to EMIT, with S=K25, rc=5'h1A (one step past RC[24]) and rk_idx=25.
  - EMIT: rk_valid=1. On a handshake with rk_idx>0, it sets rc<=rc_prev, applies the inverse round with rc_prev to S, and decrements rk_idx. On a handshake with rk_idx==0 it returns to IDLE.
- start while busy is ignored. It is not queued.
- rk_data and rk_idx hold stable while rk_valid && !rk_ready.

## Timing
- Reset values: busy=0, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, ks_err=0, FSM=IDLE, S=0, rc=01.
- Start accepted at edge N. rk_valid first rises after edge N+25, so K25 is presented 25 cycles after acceptance.
- With rk_ready held high, one key is emitted per cycle. The full run is 25+26=51 cycles, from start to the cycle after the K0 handshake.
- busy falls, and rk_valid falls, on the edge that accepts K0. A new start is accepted the following cycle.
- rst asserted mid-FWD or mid-EMIT forces IDLE and all outputs to their reset values immediately. A partially emitted sequence is discarded.
- Outputs are registered except rk_last, which is a combinational decode of registers.

## Configuration
- RECT_INV_KS_SELFCHECK_EN
- Defined:
  - master_key is latched at start.
  - On the K0 handshake, S is compared to the latched key; on mismatch ks_err is set to 1.
  - ks_err is sticky until rst or the next accepted start.
- Undefined: no latch or comparator is built, and ks_err is tied to 0.

## Test plan
- All-zero master_key, rk_ready=1 -> K25 presented 25 cycles after start, rk_idx 25..0, exactly 26 handshakes. The idx=1 key is rk_data=64'h0000_0000_000F_000E. The idx=0 key is 64'h0, with rk_last=1.
- Random key, compared against a software forward model of K0..K25 -> every emitted rk_data matches the model in reverse order. With the macro defined, ks_err stays 0.
- rk_ready toggled at random with long stalls -> rk_data and rk_idx are stable during stalls, with no skipped or duplicated index.
- start pulsed during FWD and during EMIT -> ignored, and the sequence is unchanged.
- rst asserted at rk_idx=12 -> busy, rk_valid and rk_idx are 0 immediately. A fresh start afterwards produces a full correct run.
- Macro defined, S forced corrupted by force at the idx=5 handshake -> ks_err=1 after the K0 handshake, and cleared by the next start.

Source files
------------

// File: rtl/rectangle_inv_key_schedule.sv
// RECTANGLE-80 decryption key scheduler: emits round keys K25 down to K0.
// Optional self-check of the final state against the master key: RECT_INV_KS_SELFCHECK_EN.
module rectangle_inv_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] master_key,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [63:0] rk_data,
    output logic [4:0]  rk_idx,
    output logic        rk_last,
    output logic        ks_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t      state;
    logic [79:0] s;
    logic [4:0]  rc;
    logic [4:0]  cnt;
    logic [4:0]  rc_next;
    logic [4:0]  rc_prev;
    logic [79:0] fwd_s;
    logic [79:0] inv_s;
    logic        hs;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h6;
            4'h1: return 4'h5;
            4'h2: return 4'hC;
            4'h3: return 4'hA;
            4'h4: return 4'h1;
            4'h5: return 4'hE;
            4'h6: return 4'h7;
            4'h7: return 4'h9;
            4'h8: return 4'hB;
            4'h9: return 4'h0;
            4'hA: return 4'h3;
            4'hB: return 4'hD;
            4'hC: return 4'h8;
            4'hD: return 4'hF;
            4'hE: return 4'h4;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h9;
            4'h1: return 4'h4;
            4'h2: return 4'hF;
            4'h3: return 4'hA;
            4'h4: return 4'hE;
            4'h5: return 4'h1;
            4'h6: return 4'h0;
            4'h7: return 4'h6;
            4'h8: return 4'hC;
            4'h9: return 4'h7;
            4'hA: return 4'h3;
            4'hB: return 4'h8;
            4'hC: return 4'h2;
            4'hD: return 4'hB;
            4'hE: return 4'h5;
            default: return 4'hD;
        endcase
    endfunction

    function automatic logic [15:0] rotl8(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [15:0] rotl12(input logic [15:0] x);
        return {x[3:0], x[15:4]};
    endfunction

    function automatic logic [79:0] fwd_round(input logic [79:0] x,
                                              input logic [4:0]  c);
        logic [15:0] r0, r1, r2, r3, r4;
        logic [3:0]  n;
        r0 = x[15:0];
        r1 = x[31:16];
        r2 = x[47:32];
        r3 = x[63:48];
        r4 = x[79:64];
        for (int j = 0; j < 4; j++) begin
            n = sbox({r3[j], r2[j], r1[j], r0[j]});
            r0[j] = n[0];
            r1[j] = n[1];
            r2[j] = n[2];
            r3[j] = n[3];
        end
        return {r0, rotl12(r3) ^ r4, r3, r2,
                rotl8(r0) ^ r1 ^ {11'd0, c}};
    endfunction

    function automatic logic [79:0] inv_round(input logic [79:0] x,
                                              input logic [4:0]  c);
        logic [15:0] a0, b0, b1, b2, b3, b4;
        logic [3:0]  n;
        a0 = x[15:0] ^ {11'd0, c};
        b0 = x[79:64];
        b4 = x[63:48] ^ rotl12(x[47:32]);
        b3 = x[47:32];
        b2 = x[31:16];
        b1 = a0 ^ rotl8(b0);
        for (int j = 0; j < 4; j++) begin
            n = inv_sbox({b3[j], b2[j], b1[j], b0[j]});
            b0[j] = n[0];
            b1[j] = n[1];
            b2[j] = n[2];
            b3[j] = n[3];
        end
        return {b4, b3, b2, b1, b0};
    endfunction

    // Round datapath: one forward and one inverse round evaluated per cycle
    always_comb begin
        rc_next = {rc[3:0], rc[4] ^ rc[2]};
        rc_prev = {rc[0] ^ rc[3], rc[4:1]};
        fwd_s   = fwd_round(s, rc);
        inv_s   = inv_round(s, rc_prev);
        hs      = rk_valid && rk_ready;
    end

    assign rk_last = rk_valid && (rk_idx == 5'd0);

    // Control FSM with registered key outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            rc       <= 5'h01;
            cnt      <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        s     <= master_key;
                        rc    <= 5'h01;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= FWD;
                    end
                end
                FWD: begin
                    s   <= fwd_s;
                    rc  <= rc_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd24) begin
                        state    <= EMIT;
                        rk_valid <= 1'b1;
                        rk_idx   <= 5'd25;
                        rk_data  <= fwd_s[63:0];
                    end
                end
                EMIT: begin
                    if (hs) begin
                        if (rk_idx != 5'd0) begin
                            s       <= inv_s;
                            rc      <= rc_prev;
                            rk_idx  <= rk_idx - 5'd1;
                            rk_data <= inv_s[63:0];
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rk_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RECT_INV_KS_SELFCHECK_EN
    logic [79:0] key_q;

    // Latch K0 at start; flag a mismatch when the walk back ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            ks_err <= 1'b0;
        end else if (state == IDLE && start) begin
            key_q  <= master_key;
            ks_err <= 1'b0;
        end else if (state == EMIT && hs && rk_idx == 5'd0 && s != key_q) begin
            ks_err <= 1'b1;
        end
    end
`else
    assign ks_err = 1'b0;
`endif

endmodule
